// File: rtl/xotr_multibyte_adcsbc_seq.sv
// Byte-serial N-byte ADC/SBC HL,ss sequencer driving the shared 8-bit ALU.
// Optional ADD HL,ss mode is enabled by defining XOTR_MBSEQ_ADD_EN.
module xotr_multibyte_adcsbc_seq #(
    parameter  int NBYTES        = 2,
    parameter  int SETTLE_CYCLES = 1,
    localparam int IDXW          = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      source,
    input  logic            carry_flag_in,
    input  logic            alu_carry_out,
    input  logic            alu_zero,
    input  logic            alu_sign,
    input  logic            alu_overflow,
    input  logic            alu_half,
    output logic            busy,
    output logic            alu_valid,
    output logic            alu_sbc,
    output logic            alu_carry_in,
    output logic [IDXW-1:0] byte_index,
    output logic [1:0]      pair_sel,
    output logic            dest_write,
    output logic            flag_write,
    output logic            flag_c,
    output logic            flag_z,
    output logic            flag_pv,
    output logic            flag_s,
    output logic            flag_n,
    output logic            flag_h,
    output logic            set_cm1,
    output logic            reset_xotr,
`ifdef XOTR_MBSEQ_ADD_EN
    output logic            flag_szpv_keep,
`endif
    output logic            op_head
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PASS   = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [IDXW-1:0] LAST_K   = IDXW'(NBYTES - 1);
    localparam logic [2:0]      LAST_W   = 3'(SETTLE_CYCLES - 1);
    localparam bit              HAS_WAIT = (SETTLE_CYCLES > 0);

    // ADD HL,ss encoding: 00ss1001
    function automatic logic is_add_op(input logic [7:0] op);
        return (op[7:6] == 2'b00) && (op[3:0] == 4'b1001);
    endfunction

    state_t            state_q, state_d;
    logic [IDXW-1:0]   k_q, k_d;
    logic [2:0]        wait_q, wait_d;
    logic              sbc_q, carry_q, zacc_q;
    logic [1:0]        pair_q;
    logic              fc_q, fz_q, fpv_q, fs_q, fn_q, fh_q;
    logic              launch_sbc_s, launch_carry_s;
`ifdef XOTR_MBSEQ_ADD_EN
    logic              add_q;
    logic              launch_add_s;
`endif

    // Mode decode applied at launch
    always_comb begin
`ifdef XOTR_MBSEQ_ADD_EN
        launch_add_s   = is_add_op(source);
        launch_sbc_s   = ~launch_add_s & ~source[3];
        launch_carry_s = launch_add_s ? 1'b0 : carry_flag_in;
`else
        launch_sbc_s   = ~source[3];
        launch_carry_s = carry_flag_in;
`endif
    end

    // State, byte counter and settle counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PASS;
                    k_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PASS: begin
                if (k_q == LAST_K) begin
                    state_d = S_FINISH;
                end else if (HAS_WAIT) begin
                    state_d = S_WAIT;
                    wait_d  = 3'd0;
                end else begin
                    state_d = S_PASS;
                    k_d     = k_q + IDXW'(1);
                end
            end
            S_WAIT: begin
                if (wait_q == LAST_W) begin
                    state_d = S_PASS;
                    k_d     = k_q + IDXW'(1);
                end else begin
                    wait_d  = wait_q + 3'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Latched operation context, carry chain, Z accumulator and committed flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sbc_q   <= 1'b0;
            pair_q  <= 2'b00;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fpv_q   <= 1'b0;
            fs_q    <= 1'b0;
            fn_q    <= 1'b0;
            fh_q    <= 1'b0;
`ifdef XOTR_MBSEQ_ADD_EN
            add_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sbc_q   <= launch_sbc_s;
                        pair_q  <= source[5:4];
                        carry_q <= launch_carry_s;
                        zacc_q  <= 1'b1;
`ifdef XOTR_MBSEQ_ADD_EN
                        add_q   <= launch_add_s;
`endif
                    end
                end
                S_PASS: begin
                    carry_q <= alu_carry_out;
                    zacc_q  <= zacc_q & alu_zero;
                    // Flags become visible on entry to FINISH and hold afterwards
                    if (k_q == LAST_K) begin
                        fc_q  <= alu_carry_out;
                        fz_q  <= zacc_q & alu_zero;
                        fs_q  <= alu_sign;
                        fpv_q <= alu_overflow;
                        fh_q  <= alu_half;
                        fn_q  <= sbc_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        busy       = 1'b0;
        alu_valid  = 1'b0;
        dest_write = 1'b0;
        flag_write = 1'b0;
        set_cm1    = 1'b0;
        reset_xotr = 1'b0;
        op_head    = 1'b0;
`ifdef XOTR_MBSEQ_ADD_EN
        flag_szpv_keep = 1'b0;
`endif
        case (state_q)
            S_PASS: begin
                busy       = 1'b1;
                alu_valid  = 1'b1;
                dest_write = 1'b1;
            end
            S_WAIT: busy = 1'b1;
            S_FINISH: begin
                busy       = 1'b1;
                flag_write = 1'b1;
                set_cm1    = 1'b1;
                reset_xotr = 1'b1;
                op_head    = 1'b1;
`ifdef XOTR_MBSEQ_ADD_EN
                flag_szpv_keep = add_q;
`endif
            end
            default: begin
            end
        endcase
        alu_sbc      = sbc_q;
        alu_carry_in = carry_q;
        byte_index   = k_q;
        pair_sel     = pair_q;
        flag_c       = fc_q;
        flag_z       = fz_q;
        flag_pv      = fpv_q;
        flag_s       = fs_q;
        flag_n       = fn_q;
        flag_h       = fh_q;
    end

endmodule

// File: doc/xotr_multibyte_adcsbc_seq.md
Name: xotr_multibyte_adcsbc_seq

Overview:
- Sequenced, parametrised successor to the single-step ADC/SBC HL,ss decoder.
- Runs an N-byte ADC or SBC of a register pair into HL-class destinations as byte-serial passes over the shared 8-bit ALU.
- Owns its own step counter instead of decoding the global XPT. Chains carry between passes, accumulates Z across passes, and emits the end-of-op strobes (Set CM1, Reset XOTR, op-head) that return control to fetch.

Parameters:
- NBYTES, 2, operand width in bytes; legal range 1..8.
- SETTLE_CYCLES, 1, idle wait cycles between consecutive byte passes (ALU/regfile settle); legal range 0..7.
- IDXW, derived as max(1, clog2(NBYTES)), width of byte_index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch request; honoured only in IDLE.
- source  in  8  opcode byte; bit3 selects mode (0 = SBC, 1 = ADC), bits5:4 select pair (00 BC, 01 DE, 10 HL, 11 SP).
- carry_flag_in  in  1  current C flag, sampled at start.
- alu_carry_out  in  1  ALU carry/borrow of the current pass.
- alu_zero  in  1  ALU result byte == 0.
- alu_sign  in  1  ALU result bit7.
- alu_overflow  in  1  ALU signed overflow.
- alu_half  in  1  ALU half carry/borrow.
- busy  out  1  high from first PASS through FINISH.
- alu_valid  out  1  high in PASS cycles only.
- alu_sbc  out  1  latched mode is SBC.
- alu_carry_in  out  1  carry into the current pass.
- byte_index  out  IDXW  current byte, 0 = least significant.
- pair_sel  out  2  latched source[5:4].
- dest_write  out  1  write-back strobe for byte_index of HL-class destination.
- flag_write  out  1  commit the flags below; FINISH only.
- flag_c, flag_z, flag_pv, flag_s, flag_n, flag_h  out  1 each  final flags.
- set_cm1  out  1  FINISH pulse.
- reset_xotr  out  1  FINISH pulse.
- op_head  out  1  FINISH pulse.

Behaviour:
- Reset (async, any state): state = IDLE; every output 0; latched source, carry and Z accumulator cleared. An operation in flight is abandoned with no FINISH pulses.
- States: IDLE, PASS, WAIT, FINISH.
- IDLE
  - On start=1: latch source[5:3] and carry_flag_in, set k=0, set z_acc=1, go to PASS.
  - start=0: stay in IDLE.
- PASS
  - alu_valid=1, dest_write=1, byte_index=k.
  - alu_carry_in = latched carry_flag_in when k=0, otherwise the carry registered from pass k-1.
  - On the clock edge: register alu_carry_out, z_acc &= alu_zero, capture alu_sign, alu_overflow and alu_half.
  - If k==NBYTES-1, go to FINISH. Otherwise go to WAIT if SETTLE_CYCLES>0, else go to PASS with k+1.
- WAIT: count SETTLE_CYCLES cycles with alu_valid=0 and dest_write=0, then go to PASS with k+1.
- FINISH (exactly one cycle), then IDLE:
  - flag_write=1, set_cm1=1, reset_xotr=1, op_head=1.
  - flag_c = last registered carry; flag_z = z_acc.
  - flag_s, flag_pv, flag_h = values captured in the last pass.
  - flag_n = latched SBC.
- The flag outputs hold their values until the next FINISH or reset.
- Latency: start sampled at edge 0; PASS k occupies cycle 1+k*(1+SETTLE_CYCLES); FINISH follows the last PASS. Total cycles = (NBYTES-1)*(1+SETTLE_CYCLES)+2.
- NBYTES=1: PASS0 goes directly to FINISH, and alu_carry_in = carry_flag_in.
- start while busy is ignored and not queued.
- start asserted in the FINISH cycle is ignored. start in the following IDLE cycle is accepted.
- source and carry_flag_in changes after launch have no effect.

Optional Feature:
- Macro: XOTR_MBSEQ_ADD_EN.
- With the macro defined:
  - source pattern 00xx1001 (ADD HL,ss) is accepted as a third mode.
  - alu_carry_in=0 on pass 0.
  - alu_sbc=0, flag_n=0.
  - In FINISH, flag_write asserts, but only C, N and H are committed. A separate output, flag_szpv_keep, is 1 in that case and tells the flag register to hold S, Z and P/V.
- Without the macro:
  - there is no flag_szpv_keep port.
  - source bit3 alone selects ADC/SBC and bits 7:6 are ignored.

Test Plan:
- NBYTES=2, SETTLE=1, source=0x4A (ADC HL,BC), C=1; ALU model HL=0x00FF, BC=0x0000 -> pass0 carry_in=1, byte 0x00, carry out 1; pass1 carry_in=1, byte 0x01; FINISH at cycle 4 with flag_c=0, flag_z=0, flag_n=0, and all four FINISH strobes high for exactly 1 cycle.
- NBYTES=2, SETTLE=0, source=0x52 (SBC HL,DE), C=0, HL=DE=0x1234 -> pair_sel=01, alu_sbc=1, FINISH at cycle 3 with flag_z=1, flag_c=0, flag_n=1.
- Z accumulation: low byte nonzero, high byte zero -> flag_z=0. Also assert that Z is never taken from the last pass alone.
- Reset at cycle 2 of an NBYTES=4 run -> all outputs 0 immediately; no set_cm1 pulse; a fresh start afterwards runs a full 4 passes.
- start held high continuously for NBYTES=2, SETTLE=1 -> back-to-back ops with PASS0 at cycles 1 and 6; busy low only in the IDLE cycle (cycle 5) between ops.
- NBYTES=1 and NBYTES=8 (SETTLE=2) -> total latencies of 2 and 23 cycles respectively; byte_index sweeps 0..7.
